// File: rtl/mm_ctrl.sv
// mm_ctrl: sequencing controller for a SIZE x SIZE weight-stationary systolic array.
// Optional run-length counter perf_cycles is built only when MM_CTRL_PERF_EN is defined.
module mm_ctrl #(
    parameter int SIZE      = 4,
    parameter int ADDR_W    = 8,
    parameter int ARRAY_LAT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] n_rows,
    output logic              ready,
    output logic              done,
    output logic              b_rd,
    output logic [ADDR_W-1:0] b_addr,
    output logic [SIZE-1:0]   b_load,
    output logic              a_rd,
    output logic [ADDR_W-1:0] a_addr,
    output logic [SIZE-1:0]   a_en,
    output logic              y_wr,
    output logic [ADDR_W-1:0] y_addr,
    output logic [31:0]       perf_cycles
);

    // state | meaning
    // IDLE  | waiting for start, ready=1
    // LOAD  | reading B rows 0..SIZE-1 into the weight latches
    // FEED  | reading A rows 0..n_rows-1 into the array
    // DRAIN | waiting for the last Y row write
    // DONE  | one-cycle done pulse
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_DRAIN, S_DONE} state_t;

    // One shift register serves both the row skew taps and the result-write tap.
    localparam int PIPE_A = (SIZE > ARRAY_LAT + 1) ? SIZE : ARRAY_LAT + 1;
    localparam int PIPE_W = (PIPE_A < 2) ? 2 : PIPE_A;

    state_t            state, state_next;
    logic [ADDR_W-1:0] n_lat;
    logic [PIPE_W-1:0] pipe;
    logic              accept, load_last, feed_last, y_last;

    assign accept    = (state == S_IDLE) && start && !abort;
    assign load_last = (b_addr == ADDR_W'(SIZE - 1));
    assign feed_last = (a_addr == n_lat - ADDR_W'(1));
    assign y_last    = y_wr && (y_addr == n_lat - ADDR_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        b_rd       = 1'b0;
        a_rd       = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_next = (n_rows != '0) ? S_LOAD : S_DONE;
            end
            S_LOAD: begin
                b_rd = 1'b1;
                if (load_last) state_next = S_FEED;
            end
            S_FEED: begin
                a_rd = 1'b1;
                if (feed_last) state_next = S_DRAIN;
            end
            S_DRAIN: if (y_last) state_next = S_DONE;
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (abort) state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            n_lat  <= '0;
            b_addr <= '0;
            a_addr <= '0;
            y_addr <= '0;
            b_load <= '0;
            pipe   <= '0;
        end else begin
            if (accept) n_lat <= n_rows;
            b_addr <= (b_rd && !load_last) ? b_addr + ADDR_W'(1) : '0;
            a_addr <= (a_rd && !feed_last) ? a_addr + ADDR_W'(1) : '0;
            if (state == S_IDLE || state == S_DONE) y_addr <= '0;
            else if (y_wr)                          y_addr <= y_addr + ADDR_W'(1);
            // Buffer read data arrives one cycle after b_rd, so the latch enable trails it.
            b_load <= b_rd ? (SIZE'(1) << b_addr) : '0;
            pipe   <= {pipe[PIPE_W-2:0], a_rd};
        end
    end

    assign a_en = pipe[SIZE-1:0];
    assign y_wr = pipe[ARRAY_LAT];

`ifdef MM_CTRL_PERF_EN
    logic [31:0] perf_q;

    // Survives abort on purpose so the partial run length stays visible.
    always_ff @(posedge clk) begin
        if (!rst_n)                perf_q <= '0;
        else if (accept)           perf_q <= '0;
        else if (state != S_IDLE)  perf_q <= perf_q + 32'd1;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_mm_ctrl.sv
// Self-checking bench for mm_ctrl: cycle-indexed strobe model plus a Y-address scoreboard.
module tb_mm_ctrl;
    localparam int SIZE   = 4;
    localparam int ADDR_W = 8;
    localparam int LAT    = 8;
    localparam int VW     = 5 + 2 * SIZE;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] n_rows = '0;
    logic              ready, done, b_rd, a_rd, y_wr;
    logic [ADDR_W-1:0] b_addr, a_addr, y_addr;
    logic [SIZE-1:0]   b_load, a_en;
    logic [31:0]       perf_cycles;

    int checks = 0;
    int errors = 0;
    int yq[$];

    mm_ctrl #(.SIZE(SIZE), .ADDR_W(ADDR_W), .ARRAY_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .n_rows(n_rows),
        .ready(ready), .done(done), .b_rd(b_rd), .b_addr(b_addr), .b_load(b_load),
        .a_rd(a_rd), .a_addr(a_addr), .a_en(a_en), .y_wr(y_wr), .y_addr(y_addr),
        .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    // Expected {ready,done,b_rd,b_load,a_rd,a_en,y_wr} in cycle c after the accepting edge.
    function automatic logic [VW-1:0] exp_vec(input int c, input int n);
        logic rdy, dn, brd, ard, yw;
        logic [SIZE-1:0] bl, ae;
        int d, t;
        d   = (n == 0) ? 1 : SIZE + n + 2 + LAT;
        rdy = (c > d);
        dn  = (c == d);
        brd = (n > 0) && (c >= 1) && (c <= SIZE);
        bl  = '0;
        if (n > 0 && c >= 2 && c <= SIZE + 1) bl[c-2] = 1'b1;
        ard = (n > 0) && (c >= SIZE + 1) && (c <= SIZE + n);
        ae  = '0;
        for (int k = 0; k < SIZE; k++) begin
            t = c - 1 - k;
            ae[k] = (n > 0) && (t >= SIZE + 1) && (t <= SIZE + n);
        end
        t  = c - 1 - LAT;
        yw = (n > 0) && (t >= SIZE + 1) && (t <= SIZE + n);
        return {rdy, dn, brd, bl, ard, ae, yw};
    endfunction

    task automatic test_reset();
        logic [VW-1:0] obs, ev;
        rst_n = 1'b0;
        start = 1'b1;
        n_rows = ADDR_W'(3);
        repeat (3) @(negedge clk);
        obs = {ready, done, b_rd, b_load, a_rd, a_en, y_wr};
        ev  = {1'b1, {(VW-1){1'b0}}};
        checks++;
        if (obs !== ev) begin
            errors++;
            $display("FAIL reset_strobes got=%b want=%b", obs, ev);
        end
        checks++;
        if ({b_addr, a_addr, y_addr} !== '0 || perf_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_addr got b=%0d a=%0d y=%0d perf=%0d want all 0",
                     b_addr, a_addr, y_addr, perf_cycles);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release ready got=%b want=1", ready);
        end
    endtask

    // One checked run. abort_at/rst_at/pulse_at are cycle numbers (0 = unused);
    // b2b raises start in the done cycle and leaves it for the next run to hold.
    task automatic test_run(input string tag, input int n, input int abort_at,
                            input int rst_at, input int pulse_at, input bit b2b);
        logic [VW-1:0] obs, ev;
        int d, cut, last, e;
        logic [31:0] perf_exp;
        d    = (n == 0) ? 1 : SIZE + n + 2 + LAT;
        cut  = (abort_at != 0) ? abort_at : rst_at;
        last = (abort_at != 0) ? cut + 1 : (rst_at != 0) ? cut + 8 : d + 1;
        start  = 1'b1;
        n_rows = ADDR_W'(n);
        for (int i = 0; i < n; i++) yq.push_back(i);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            obs = {ready, done, b_rd, b_load, a_rd, a_en, y_wr};
            ev  = (cut != 0 && c > cut) ? {1'b1, {(VW-1){1'b0}}} : exp_vec(c, n);
            checks++;
            if (obs !== ev) begin
                errors++;
                $display("FAIL %s_strobes n=%0d c=%0d got=%b want=%b", tag, n, c, obs, ev);
            end
            if (b_rd) begin
                checks++;
                if (b_addr !== ADDR_W'(c - 1)) begin
                    errors++;
                    $display("FAIL %s_b_addr c=%0d got=%0d want=%0d", tag, c, b_addr, c - 1);
                end
            end
            if (a_rd) begin
                checks++;
                if (a_addr !== ADDR_W'(c - SIZE - 1)) begin
                    errors++;
                    $display("FAIL %s_a_addr c=%0d got=%0d want=%0d", tag, c, a_addr, c - SIZE - 1);
                end
            end
            if (y_wr) begin
                checks++;
                if (yq.size() == 0) begin
                    errors++;
                    $display("FAIL %s_y_extra c=%0d got y_addr=%0d want no write", tag, c, y_addr);
                end else begin
                    e = yq.pop_front();
                    if (y_addr !== ADDR_W'(e)) begin
                        errors++;
                        $display("FAIL %s_y_addr c=%0d got=%0d want=%0d", tag, c, y_addr, e);
                    end
                end
            end
            start = (c == pulse_at) || (b2b && c == d);
            if (c == pulse_at) n_rows = ADDR_W'(1);
            abort = (c == abort_at);
            rst_n = !(c == rst_at);
        end
        if (cut != 0) yq.delete();
        checks++;
        if (yq.size() != 0) begin
            errors++;
            $display("FAIL %s_y_missing got %0d writes left want 0", tag, yq.size());
            yq.delete();
        end
`ifdef MM_CTRL_PERF_EN
        perf_exp = (abort_at != 0) ? 32'(abort_at) : (rst_at != 0) ? 32'd0 : 32'(d);
`else
        perf_exp = 32'd0;
`endif
        checks++;
        if (perf_cycles !== perf_exp) begin
            errors++;
            $display("FAIL %s_perf got=%0d want=%0d", tag, perf_cycles, perf_exp);
        end
    endtask

    initial begin
        test_reset();
        test_run("basic", 3, 0, 0, 0, 1'b0);
        test_run("zero", 0, 0, 0, 0, 1'b0);
        test_run("long", 20, 0, 0, 0, 1'b0);
        test_run("abort", 3, 6, 0, 0, 1'b0);
        test_run("after_abort", 2, 0, 0, 0, 1'b0);
        test_run("b2b_first", 5, 0, 0, SIZE + 2, 1'b1);
        test_run("b2b_second", 2, 0, 0, 0, 1'b0);
        test_run("reset_mid", 3, 0, 10, 0, 1'b0);
        test_run("after_reset", 1, 0, 0, 0, 1'b0);
        start = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
